// File: rtl/d_BCH_pkg.sv
// Shared BCH decoder package: GF(2^12) parameters, Chien search sizing,
// Chien search state encoding and an elaboration-time alpha power helper.
package d_BCH_pkg;

  localparam int Multi             = 2;
  localparam int GaloisFieldDegree = 12;
  localparam int MaxErrorCountBits = 9;
  localparam int ELPCoefficients   = 15;
  localparam int CodewordLength    = 4095;
  localparam int PositionBits      = 12;
  localparam logic [GaloisFieldDegree-1:0] PrimitivePoly = 12'h053;

  // One lane's slice of a coefficient word, and the full packed ELP bus.
  localparam int LaneCoefBits = Multi * GaloisFieldDegree;
  localparam int CoefBusBits  = LaneCoefBits * ELPCoefficients;

  // One-hot Chien search states.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_SEARCH = 4'b0100,
    ST_DONE   = 4'b1000
  } cs_state_e;

  // alpha^e by stepping the field LFSR e times from alpha^0 = 1.
  // Only ever called with constant arguments.
  function automatic logic [GaloisFieldDegree-1:0] gf_alpha_pow(input int e);
    logic [GaloisFieldDegree-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    for (int i = 0; i < e; i++) begin
      v = {v[GaloisFieldDegree-2:0], 1'b0} ^ (v[GaloisFieldDegree-1] ? PrimitivePoly : '0);
    end
    return v;
  endfunction

endpackage

// File: rtl/d_cs_serial_search_if.sv
// Bus bundle of the Chien search stage.
//   Launch side : i_exe_cs, i_kes_sequence_end, i_kes_fail, i_error_count,
//                 i_ELP_coef, i_stop_dec, o_cs_available
//   Beat stream : o_cs_valid, i_out_ready, o_position, o_error_location
//   Verdict     : o_cs_done, o_cs_fail
//   Debug       : o_dbg_state (current FSM state)
// Handshake: a position beat transfers on a rising edge where o_cs_valid and
// i_out_ready are both 1; while o_cs_valid=1 and i_out_ready=0 the beat
// (o_position, o_error_location) holds unchanged, and o_cs_valid never drops
// before its beat has transferred (except on i_stop_dec / reset).
interface d_cs_serial_search_if;
  import d_BCH_pkg::*;

  logic                               i_stop_dec;
  logic                               i_exe_cs;
  logic [Multi-1:0]                   i_kes_sequence_end;
  logic [Multi-1:0]                   i_kes_fail;
  logic [Multi*MaxErrorCountBits-1:0] i_error_count;
  logic [CoefBusBits-1:0]             i_ELP_coef;
  logic                               i_out_ready;
  logic                               o_cs_available;
  logic                               o_cs_valid;
  logic [PositionBits-1:0]            o_position;
  logic [Multi-1:0]                   o_error_location;
  logic                               o_cs_done;
  logic [Multi-1:0]                   o_cs_fail;
  cs_state_e                          o_dbg_state;

  modport slave (
    input  i_stop_dec, i_exe_cs, i_kes_sequence_end, i_kes_fail,
           i_error_count, i_ELP_coef, i_out_ready,
    output o_cs_available, o_cs_valid, o_position, o_error_location,
           o_cs_done, o_cs_fail, o_dbg_state
  );

  modport master (
    output i_stop_dec, i_exe_cs, i_kes_sequence_end, i_kes_fail,
           i_error_count, i_ELP_coef, i_out_ready,
    input  o_cs_available, o_cs_valid, o_position, o_error_location,
           o_cs_done, o_cs_fail, o_dbg_state
  );

endinterface

// File: rtl/d_CS_gf_const_mul.sv
// Combinational multiply of a GF(2^12) element by the constant alpha^Exponent.
//   i_data : field element
//   o_data : i_data * alpha^Exponent
// Bit j of the input contributes alpha^(Exponent+j), so the product is the XOR
// of those constant columns selected by the input bits.
module d_CS_gf_const_mul
  import d_BCH_pkg::*;
#(
  parameter int Exponent = 1
) (
  input  logic [GaloisFieldDegree-1:0] i_data,
  output logic [GaloisFieldDegree-1:0] o_data
);

  logic [GaloisFieldDegree-1:0] col [GaloisFieldDegree];

  for (genvar j = 0; j < GaloisFieldDegree; j++) begin : g_col
    localparam logic [GaloisFieldDegree-1:0] ColVal = gf_alpha_pow(Exponent + j);
    assign col[j] = ColVal;
  end

  always_comb begin
    o_data = '0;
    for (int j = 0; j < GaloisFieldDegree; j++) begin
      if (i_data[j]) o_data = o_data ^ col[j];
    end
  end

endmodule

// File: rtl/d_cs_serial_search.sv
// Chien search: evaluates each lane's error locator polynomial at alpha^p for
// p = 0..CodewordLength-1, one position per accepted beat, all lanes in
// parallel, then reports a per-lane decode-fail verdict.
//   i_clk, i_RESET : clock, asynchronous active-high reset
//   bus (slave)    : launch inputs, beat stream, verdict, debug state
module d_cs_serial_search
  import d_BCH_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_RESET,
  d_cs_serial_search_if.slave  bus
);

  typedef logic [GaloisFieldDegree-1:0] gf_t;
  typedef logic [MaxErrorCountBits-1:0] cnt_t;

  localparam logic [PositionBits-1:0] LastPos = PositionBits'(CodewordLength - 1);

  cs_state_e               state_q, state_d;
  logic [Multi-1:0]        en_q, en_d;
  logic [Multi-1:0]        kfail_q, kfail_d;
  logic [Multi-1:0]        err_q, err_d;
  logic [Multi-1:0]        fail_q, fail_d;
  cnt_t                    cnt_q [Multi];
  cnt_t                    cnt_d [Multi];
  cnt_t                    root_q [Multi];
  cnt_t                    root_d [Multi];
  gf_t                     term_q [Multi][ELPCoefficients];
  gf_t                     term_d [Multi][ELPCoefficients];
  gf_t                     term_mul [Multi][ELPCoefficients];
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [PositionBits-1:0] pos_q, pos_d;

  gf_t                     sum_now [Multi];
  gf_t                     sum_next [Multi];
  logic [Multi-1:0]        zero_now, zero_next;

  // term_mul[m][k] = term_q[m][k] * alpha^k: the terms for the next position.
  for (genvar m = 0; m < Multi; m++) begin : g_lane
    assign term_mul[m][0] = term_q[m][0];
    for (genvar k = 1; k < ELPCoefficients; k++) begin : g_coef
      d_CS_gf_const_mul #(.Exponent(k)) u_mul (
        .i_data (term_q[m][k]),
        .o_data (term_mul[m][k])
      );
    end
  end

  // Lambda evaluated at the current position (zero_now) and at the next one
  // (zero_next). The flag output is registered, so it is computed from the
  // terms that will be held during the beat it belongs to.
  always_comb begin
    for (int m = 0; m < Multi; m++) begin
      sum_now[m]  = '0;
      sum_next[m] = '0;
      for (int k = 0; k < ELPCoefficients; k++) begin
        sum_now[m]  = sum_now[m]  ^ term_q[m][k];
        sum_next[m] = sum_next[m] ^ term_mul[m][k];
      end
      zero_now[m]  = (sum_now[m] == '0);
      zero_next[m] = (sum_next[m] == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    kfail_d = kfail_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    term_d  = term_q;
    valid_d = valid_q;
    pos_d   = pos_q;
    err_d   = err_q;
    done_d  = 1'b0;
    fail_d  = '0;

    if (bus.i_stop_dec) begin
      state_d = ST_IDLE;
      en_d    = '0;
      kfail_d = '0;
      cnt_d   = '{default: '0};
      root_d  = '{default: '0};
      term_d  = '{default: '0};
      valid_d = 1'b0;
      pos_d   = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_exe_cs) begin
            state_d = ST_LOAD;
            en_d    = bus.i_kes_sequence_end;
            kfail_d = bus.i_kes_fail;
            // Coefficients land directly in the term registers: the p=0
            // terms are lambda_k * alpha^0 = lambda_k, so no separate copy.
            for (int m = 0; m < Multi; m++) begin
              cnt_d[m] = bus.i_error_count[m*MaxErrorCountBits +: MaxErrorCountBits];
              for (int k = 0; k < ELPCoefficients; k++) begin
                term_d[m][k] = bus.i_ELP_coef[(ELPCoefficients-1-k)*LaneCoefBits + m*GaloisFieldDegree +: GaloisFieldDegree];
              end
            end
          end
        end
        ST_LOAD: begin
          state_d = ST_SEARCH;
          root_d  = '{default: '0};
          valid_d = 1'b1;
          pos_d   = '0;
          err_d   = en_q & ~kfail_q & zero_now;
        end
        ST_SEARCH: begin
          if (bus.i_out_ready) begin
            term_d = term_mul;
            for (int m = 0; m < Multi; m++) begin
              if (err_q[m] && (root_q[m] != '1)) root_d[m] = root_q[m] + 1'b1;
            end
            if (pos_q == LastPos) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              pos_d   = '0;
              err_d   = '0;
              done_d  = 1'b1;
              for (int m = 0; m < Multi; m++) begin
                fail_d[m] = en_q[m] & (kfail_q[m] | (root_d[m] != cnt_q[m]));
              end
            end else begin
              pos_d = pos_q + 1'b1;
              err_d = en_q & ~kfail_q & zero_next;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      kfail_q <= '0;
      cnt_q   <= '{default: '0};
      root_q  <= '{default: '0};
      term_q  <= '{default: '0};
      valid_q <= 1'b0;
      pos_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      kfail_q <= kfail_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      term_q  <= term_d;
      valid_q <= valid_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.o_cs_available   = (state_q == ST_IDLE);
  assign bus.o_cs_valid       = valid_q;
  assign bus.o_position       = pos_q;
  assign bus.o_error_location = err_q;
  assign bus.o_cs_done        = done_q;
  assign bus.o_cs_fail        = fail_q;
  assign bus.o_dbg_state      = state_q;

endmodule
